spi_master_rx: RTL and testbench
================================

Name: spi_master_rx

Overview:
SPI master receive datapath. It samples MISO (sdi1) in standard mode, or sdi0..sdi3 in quad mode, on each rx_edge strobe from the clock generator. It assembles 32-bit words and pushes them to the RX FIFO over a valid/ready handshake. It gates the SPI clock through clk_en_o, stalling the bus whenever the FIFO applies back-pressure.

Parameters:
None. Word width is fixed at 32 bits and the bit counter is fixed at 16 bits.

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
en  in  1  start request, sampled in IDLE only
rx_edge  in  1  single-cycle sample strobe from the SPI clock generator
rx_done  out  1  transfer-complete pulse
sdi0  in  1  quad data bit 0
sdi1  in  1  quad data bit 1; MISO in standard mode
sdi2  in  1  quad data bit 2
sdi3  in  1  quad data bit 3
en_quad_in  in  1  1 = quad mode (4 bits per edge), 0 = standard mode (1 bit per edge)
counter_in  in  16  transfer length in bits
counter_in_upd  in  1  load counter_in into the target register
data  out  32  received word to the FIFO
data_valid  out  1  word available
data_ready  in  1  FIFO accepts the word
clk_en_o  out  1  SPI clock enable

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE, counter = 0, counter_trgt = 8, data_int = 0.
  - Outputs: data_valid = 0, data = 0, clk_en_o = 0, rx_done = 0.
- Target register:
  - When counter_in_upd = 1, counter_trgt <= (en_quad_in ? counter_in >> 2 : counter_in) on the next clk. This happens in any state.
  - counter_trgt = 0 is illegal; behaviour is undefined and is not verified.
- Word boundary (reg_done):
  - Standard mode: counter[4:0] == 31.
  - Quad mode: counter[2:0] == 7.
- Transfer end: rx_done = rx_edge && (counter == counter_trgt - 1) && state == RECEIVE. rx_done is combinational.
- Shift on rx_edge while in RECEIVE:
  - data_int_next = quad ? {data_int[27:0], sdi3, sdi2, sdi1, sdi0} : {data_int[30:0], sdi1}.
  - counter increments by 1.
- Output mux:
  - data = data_int_next in RECEIVE.
  - data = data_int in the WAIT states.
  - data is combinational, so a word is presented in the same cycle as its last rx_edge.
- States:
  - IDLE:
    - clk_en_o = 0, data_valid = 0.
    - If en: data_int <= 0, counter <= 0, go to RECEIVE.
  - RECEIVE:
    - clk_en_o = 1.
    - On rx_edge with rx_done (rx_done has priority over reg_done):
      - data_valid = 1 and counter <= 0.
      - If data_ready: go to IDLE, clk_en_o = 0 this cycle.
      - Otherwise: go to WAIT_FIFO_DONE, clk_en_o = 0.
    - On rx_edge with reg_done (and not rx_done):
      - data_valid = 1.
      - If data_ready: data_int <= 0 and stay in RECEIVE.
      - Otherwise: go to WAIT_FIFO, clk_en_o = 0.
    - No rx_edge: hold all state.
  - WAIT_FIFO:
    - clk_en_o = 0, data_valid = 1, data = data_int (held stable).
    - On data_ready: data_int <= 0, go to RECEIVE.
  - WAIT_FIFO_DONE:
    - Same outputs as WAIT_FIFO.
    - On data_ready: go to IDLE.
- Partial final word: a transfer that is not a multiple of 32 bits pushes a last word that is right-aligned and zero-extended, because data_int is cleared at each word start.
- en deasserted mid-transfer is ignored; the transfer runs to counter_trgt.
- rx_edge arriving in a WAIT state or in IDLE is ignored (no shift, no count). The clock generator guarantees no edges while clk_en_o = 0.
- Handshake: data_valid is never dropped before data_ready is seen; data is stable while data_valid = 1 in the WAIT states.
- One word is pushed per boundary. There is no internal buffering beyond data_int.

Test Plan:
- Standard, 32 bits, data_ready held 1:
  - Stimulus: counter_in = 32 with upd, en pulse, 32 rx_edges, MISO serialising 0xA5C3_0F96 MSB-first.
  - Required: one data_valid cycle with data = 0xA5C30F96, coincident with rx_done; then IDLE with clk_en_o = 0.
- Quad, 64 bits, ready = 1:
  - Stimulus: counter_in = 64, en_quad_in = 1, 16 edges, nibbles 0x1,0x2,…,0xF,0x0.
  - Required: words 0x12345678 then 0x9ABCDEF0; rx_done on the 16th edge.
- Back-pressure mid-transfer:
  - Stimulus: standard, 64 bits, data_ready = 0 at the first word boundary for 5 cycles.
  - Required: clk_en_o = 0 and data_valid = 1 with data stable for 5 cycles; resume in RECEIVE on ready; second word correct.
- Partial word:
  - Stimulus: standard, counter_in = 12, bits 0xABC.
  - Required: data = 0x00000ABC with rx_done.
- Back-pressure at end:
  - Stimulus: 32-bit transfer, ready = 0 at rx_done.
  - Required: WAIT_FIFO_DONE holds data_valid; on ready, go to IDLE; a new en restarts with counter = 0.
- Reset mid-RECEIVE:
  - Stimulus: assert rstn = 0 after 10 edges.
  - Required: all outputs = 0 immediately; counter_trgt = 8; a subsequent 8-bit transfer (target defaulted, no upd) yields data = 0x000000xx.

Source files
------------

// File: rtl/spi_master_rx.sv
// SPI master receive datapath: samples MISO or quad lines on rx_edge,
// assembles 32-bit words and pushes them out over valid/ready.
module spi_master_rx (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        rx_edge,
    output logic        rx_done,
    input  logic        sdi0,
    input  logic        sdi1,
    input  logic        sdi2,
    input  logic        sdi3,
    input  logic        en_quad_in,
    input  logic [15:0] counter_in,
    input  logic        counter_in_upd,
    output logic [31:0] data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        clk_en_o
);

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        WAIT_FIFO,
        WAIT_FIFO_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] counter_q, counter_d;
    logic [15:0] counter_trgt_q, counter_trgt_d;
    logic [31:0] data_int_q, data_int_d;
    logic [31:0] data_int_next;
    logic        reg_done;

    assign reg_done = en_quad_in ? (counter_q[2:0] == 3'd7)
                                 : (counter_q[4:0] == 5'd31);

    assign data_int_next = en_quad_in
        ? {data_int_q[27:0], sdi3, sdi2, sdi1, sdi0}
        : {data_int_q[30:0], sdi1};

    assign rx_done = rx_edge && (state_q == RECEIVE)
                  && (counter_q == counter_trgt_q - 16'd1);

    // Target is in edges: quad mode moves four bits per edge
    always_comb begin
        counter_trgt_d = counter_trgt_q;
        if (counter_in_upd)
            counter_trgt_d = en_quad_in ? (counter_in >> 2) : counter_in;
    end

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        data_int_d = data_int_q;
        data_valid = 1'b0;
        clk_en_o   = 1'b0;
        data       = 32'h0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    data_int_d = 32'h0;
                    counter_d  = 16'h0;
                    state_d    = RECEIVE;
                end
            end
            RECEIVE: begin
                clk_en_o = 1'b1;
                data     = data_int_next;
                if (rx_edge) begin
                    counter_d  = counter_q + 16'd1;
                    data_int_d = data_int_next;
                    if (rx_done) begin
                        data_valid = 1'b1;
                        counter_d  = 16'h0;
                        clk_en_o   = 1'b0;
                        state_d    = data_ready ? IDLE : WAIT_FIFO_DONE;
                    end else if (reg_done) begin
                        data_valid = 1'b1;
                        if (data_ready) begin
                            data_int_d = 32'h0;
                        end else begin
                            clk_en_o = 1'b0;
                            state_d  = WAIT_FIFO;
                        end
                    end
                end
            end
            WAIT_FIFO: begin
                data_valid = 1'b1;
                data       = data_int_q;
                if (data_ready) begin
                    data_int_d = 32'h0;
                    state_d    = RECEIVE;
                end
            end
            WAIT_FIFO_DONE: begin
                data_valid = 1'b1;
                data       = data_int_q;
                if (data_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            counter_q      <= 16'h0;
            counter_trgt_q <= 16'd8;
            data_int_q     <= 32'h0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            counter_trgt_q <= counter_trgt_d;
            data_int_q     <= data_int_d;
        end
    end

endmodule

// File: tb/tb_spi_master_rx.sv
// Directed bench for spi_master_rx: standard, quad, back-pressure,
// partial word and mid-transfer reset.
module tb_spi_master_rx;

    logic        clk;
    logic        rstn;
    logic        en;
    logic        rx_edge;
    logic        rx_done;
    logic        sdi0, sdi1, sdi2, sdi3;
    logic        en_quad_in;
    logic [15:0] counter_in;
    logic        counter_in_upd;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic        clk_en_o;

    int vecs = 0;
    int miscompares = 0;

    logic        l_dv, l_done, l_ce;
    logic [31:0] l_data;
    int          early;

    spi_master_rx dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .rx_edge        (rx_edge),
        .rx_done        (rx_done),
        .sdi0           (sdi0),
        .sdi1           (sdi1),
        .sdi2           (sdi2),
        .sdi3           (sdi3),
        .en_quad_in     (en_quad_in),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .data           (data),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .clk_en_o       (clk_en_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [15:0] len, input logic quad);
        en_quad_in     = quad;
        counter_in     = len;
        counter_in_upd = 1'b1;
        tick();
        counter_in_upd = 1'b0;
    endtask

    task automatic start();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic do_edge(input logic [3:0] nib);
        rx_edge = 1'b1;
        {sdi3, sdi2, sdi1, sdi0} = nib;
        @(negedge clk);
        l_dv   = data_valid;
        l_done = rx_done;
        l_ce   = clk_en_o;
        l_data = data;
        tick();
        rx_edge = 1'b0;
    endtask

    task automatic send_std(input logic [31:0] w, input int n);
        early = 0;
        for (int i = n - 1; i >= 0; i--) begin
            do_edge({2'b00, w[i], 1'b0});
            if (i != 0 && (l_dv || l_done)) early++;
        end
    endtask

    task automatic send_quad(input logic [31:0] w);
        early = 0;
        for (int i = 7; i >= 0; i--) begin
            do_edge(w[i*4 +: 4]);
            if (i != 0 && (l_dv || l_done)) early++;
        end
    endtask

    task automatic sample_outs();
        @(negedge clk);
        l_dv   = data_valid;
        l_done = rx_done;
        l_ce   = clk_en_o;
        l_data = data;
    endtask

    initial begin
        rstn = 1'b0;
        en = 1'b0;
        rx_edge = 1'b0;
        {sdi3, sdi2, sdi1, sdi0} = 4'h0;
        en_quad_in = 1'b0;
        counter_in = 16'h0;
        counter_in_upd = 1'b0;
        data_ready = 1'b1;
        #3;
        chk("rst_valid", {31'h0, data_valid}, 32'h0);
        chk("rst_data", data, 32'h0);
        chk("rst_clken", {31'h0, clk_en_o}, 32'h0);
        chk("rst_done", {31'h0, rx_done}, 32'h0);
        tick();
        rstn = 1'b1;
        tick();

        // standard 32-bit word, ready held high
        setup(16'd32, 1'b0);
        start();
        sample_outs();
        chk("s32_clken_run", {31'h0, l_ce}, 32'h1);
        tick();
        send_std(32'hA5C3_0F96, 32);
        chk("s32_early", early, 0);
        chk("s32_valid", {31'h0, l_dv}, 32'h1);
        chk("s32_done", {31'h0, l_done}, 32'h1);
        chk("s32_data", l_data, 32'hA5C3_0F96);
        chk("s32_clken_last", {31'h0, l_ce}, 32'h0);
        sample_outs();
        chk("s32_idle_clken", {31'h0, l_ce}, 32'h0);
        chk("s32_idle_valid", {31'h0, l_dv}, 32'h0);
        tick();

        // quad 64 bits: nibbles 1..F,0
        setup(16'd64, 1'b1);
        start();
        send_quad(32'h1234_5678);
        chk("q_w1_early", early, 0);
        chk("q_w1_valid", {31'h0, l_dv}, 32'h1);
        chk("q_w1_done", {31'h0, l_done}, 32'h0);
        chk("q_w1_data", l_data, 32'h1234_5678);
        chk("q_w1_clken", {31'h0, l_ce}, 32'h1);
        send_quad(32'h9ABC_DEF0);
        chk("q_w2_early", early, 0);
        chk("q_w2_valid", {31'h0, l_dv}, 32'h1);
        chk("q_w2_done", {31'h0, l_done}, 32'h1);
        chk("q_w2_data", l_data, 32'h9ABC_DEF0);
        en_quad_in = 1'b0;
        tick();

        // standard 64 bits, back-pressure at first boundary
        setup(16'd64, 1'b0);
        start();
        data_ready = 1'b0;
        send_std(32'h0F0F_1234, 32);
        chk("bp_w1_early", early, 0);
        chk("bp_w1_valid", {31'h0, l_dv}, 32'h1);
        chk("bp_w1_done", {31'h0, l_done}, 32'h0);
        chk("bp_w1_clken", {31'h0, l_ce}, 32'h0);
        chk("bp_w1_data", l_data, 32'h0F0F_1234);
        for (int k = 0; k < 5; k++) begin
            sample_outs();
            chk("bp_hold_clken", {31'h0, l_ce}, 32'h0);
            chk("bp_hold_valid", {31'h0, l_dv}, 32'h1);
            chk("bp_hold_data", l_data, 32'h0F0F_1234);
            tick();
        end
        data_ready = 1'b1;
        sample_outs();
        chk("bp_accept_valid", {31'h0, l_dv}, 32'h1);
        chk("bp_accept_data", l_data, 32'h0F0F_1234);
        tick();
        sample_outs();
        chk("bp_resume_clken", {31'h0, l_ce}, 32'h1);
        chk("bp_resume_valid", {31'h0, l_dv}, 32'h0);
        tick();
        send_std(32'hDEAD_BEEF, 32);
        chk("bp_w2_early", early, 0);
        chk("bp_w2_done", {31'h0, l_done}, 32'h1);
        chk("bp_w2_data", l_data, 32'hDEAD_BEEF);
        tick();

        // partial 12-bit word, right-aligned
        setup(16'd12, 1'b0);
        start();
        send_std(32'h0000_0ABC, 12);
        chk("part_early", early, 0);
        chk("part_done", {31'h0, l_done}, 32'h1);
        chk("part_valid", {31'h0, l_dv}, 32'h1);
        chk("part_data", l_data, 32'h0000_0ABC);
        tick();

        // back-pressure on the final word
        setup(16'd32, 1'b0);
        start();
        data_ready = 1'b0;
        send_std(32'h1357_9BDF, 32);
        chk("bpe_done", {31'h0, l_done}, 32'h1);
        chk("bpe_valid", {31'h0, l_dv}, 32'h1);
        chk("bpe_data", l_data, 32'h1357_9BDF);
        for (int k = 0; k < 3; k++) begin
            sample_outs();
            chk("bpe_hold_valid", {31'h0, l_dv}, 32'h1);
            chk("bpe_hold_data", l_data, 32'h1357_9BDF);
            chk("bpe_hold_clken", {31'h0, l_ce}, 32'h0);
            tick();
        end
        data_ready = 1'b1;
        sample_outs();
        chk("bpe_accept_valid", {31'h0, l_dv}, 32'h1);
        tick();
        sample_outs();
        chk("bpe_idle_valid", {31'h0, l_dv}, 32'h0);
        chk("bpe_idle_clken", {31'h0, l_ce}, 32'h0);
        tick();
        start();
        send_std(32'h2468_ACE0, 32);
        chk("bpe_restart_early", early, 0);
        chk("bpe_restart_done", {31'h0, l_done}, 32'h1);
        chk("bpe_restart_data", l_data, 32'h2468_ACE0);
        tick();

        // reset in the middle of a transfer
        setup(16'd32, 1'b0);
        start();
        send_std(32'h0000_03FF, 10);
        rstn = 1'b0;
        #1;
        chk("mrst_valid", {31'h0, data_valid}, 32'h0);
        chk("mrst_data", data, 32'h0);
        chk("mrst_clken", {31'h0, clk_en_o}, 32'h0);
        chk("mrst_done", {31'h0, rx_done}, 32'h0);
        tick();
        rstn = 1'b1;
        tick();
        start();
        send_std(32'h0000_005A, 8);
        chk("mrst_8_early", early, 0);
        chk("mrst_8_done", {31'h0, l_done}, 32'h1);
        chk("mrst_8_data", l_data, 32'h0000_005A);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, miscompares);
        $finish;
    end

endmodule
